// File: rtl/coproc_clk_pkg.sv
// Shared types and constants for the coprocessor clock-enable controller.
package coproc_clk_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   localparam int DEFAULT_DIV = 15;

endpackage

// File: rtl/clk_en_ctrl_if.sv
// Host-side control/status bundle of the clock-enable controller.
interface clk_en_ctrl_if #(
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8
);

   logic [CNT_W-1:0]   cfg_div;
   logic               cfg_wr;
   logic               mode;
   logic [BURST_W-1:0] burst_len;
   logic               start;
   logic               stop;
   logic               busy;
   logic               tick_en;
   logic               clk_out;
   logic               done;
   logic [CNT_W-1:0]   div_active;

   modport master (
      output cfg_div, cfg_wr, mode, burst_len, start, stop,
      input  busy, tick_en, clk_out, done, div_active
   );

   modport slave (
      input  cfg_div, cfg_wr, mode, burst_len, start, stop,
      output busy, tick_en, clk_out, done, div_active
   );

endinterface

// File: rtl/clk_en_ctrl_tick_counter.sv
// Period counter with terminal detect and shadowed divide ratio.
module tick_counter
   import coproc_clk_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int DEF_DIV = DEFAULT_DIV
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             run,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             term,
   output logic [CNT_W-1:0] div_active
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;

   always_comb begin
      term       = run && (cnt_q == div_q);
      cnt_d      = '0;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (run) begin
         cnt_d = term ? '0 : cnt_q + 1'b1;
      end
      // Ratio only moves at a period boundary while running.
      if (!run) begin
         pend_vld_d = 1'b0;
         if (cfg_wr) div_d = cfg_div;
      end else if (term) begin
         pend_vld_d = 1'b0;
         if (cfg_wr) div_d = cfg_div;
         else if (pend_vld_q) div_d = pend_q;
      end else if (cfg_wr) begin
         pend_d     = cfg_div;
         pend_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         div_q      <= CNT_W'(DEF_DIV);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign div_active = div_q;

endmodule

// File: rtl/clk_en_ctrl.sv
// Run/stop FSM driving tick_en and clk_out in continuous or burst mode.
module clk_en_ctrl
   import coproc_clk_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int BURST_W = 8,
   parameter int DEF_DIV = DEFAULT_DIV
) (
   input  logic          clk_in,
   input  logic          rst,
   clk_en_ctrl_if.slave  bus
);

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic               busy_q, busy_d;
   logic               tick_q, tick_d;
   logic               clko_q, clko_d;
   logic               done_q, done_d;
   logic               term;
   logic               last;

   tick_counter #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) u_cnt (
      .clk_in     (clk_in),
      .rst        (rst),
      .run        (state_q != IDLE),
      .cfg_wr     (bus.cfg_wr),
      .cfg_div    (bus.cfg_div),
      .term       (term),
      .div_active (bus.div_active)
   );

   assign last = (mode_q == MODE_BURST) && (rem_q == BURST_W'(1));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      clko_d  = clko_q;
      unique case (state_q)
         IDLE: begin
            clko_d = 1'b0;
            if (bus.start) begin
               if (bus.mode == MODE_BURST && bus.burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  mode_d  = bus.mode;
                  rem_d   = bus.burst_len;
               end
            end
         end
         RUN: begin
            if (term) begin
               tick_d = 1'b1;
               clko_d = ~clko_q;
               if (mode_q == MODE_BURST) rem_d = rem_q - 1'b1;
            end
            // A finishing burst wins over a coincident stop.
            if (term && last) begin
               done_d  = 1'b1;
               clko_d  = 1'b0;
               state_d = IDLE;
            end else if (bus.stop) begin
               state_d = STOP_PEND;
            end
         end
         STOP_PEND: begin
            if (term) begin
               tick_d  = 1'b1;
               done_d  = 1'b1;
               clko_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_CONT;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         tick_q  <= 1'b0;
         clko_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         tick_q  <= tick_d;
         clko_q  <= clko_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.tick_en = tick_q;
   assign bus.clk_out = clko_q;
   assign bus.done    = done_q;

endmodule
